rr_mux_arb: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with built-in arbitration. It is the sequential successor to the lab 4:1 mux. Each input channel is a valid/ready source. The block picks one requesting channel per cycle, either by round-robin or by fixed priority, and registers the winning data, with its channel index, into a single output stage that uses a valid/ready handshake. It sits between several producers and one shared consumer, for example a shared bus or display driver.

---
 rtl/ddco_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/rr_mux_arb.sv | 96 +++++++++
 tb/tb_rr_mux_arb.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ddco_pkg.sv
// Shared definitions for the arbitrated registered mux.
//   DEF_N / DEF_W   : default channel count and data width
//   arb_mode_e      : arbitration mode encoding (matches the rr_en pin)
//   onehot_to_idx   : index of the set bit in a one-hot vector (up to 32 bits)
package ddco_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // OR of set-bit positions; exact for one-hot, 0 for an all-zero vector.
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter.
//   req     : per-channel request
//   ptr     : round-robin start position
//   rr_en   : 1 = round-robin from ptr, 0 = lowest index wins
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted channel
//   any     : at least one request present
module rr_arbiter
  import ddco_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            rr_en,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic            found;
  logic [SELW-1:0] k;
  int              kk;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    k     = '0;
    kk    = 0;
    if (arb_mode_e'(rr_en) == ARB_RR) begin
      // Walk ptr, ptr+1, ... wrapping at N; first requester wins.
      for (int off = 0; off < N; off++) begin
        kk = int'(ptr) + off;
        if (kk >= N) kk = kk - N;
        k = SELW'(kk);
        if (!found && req[k]) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign any     = |req;
  assign gnt_idx = SELW'(onehot_to_idx(32'(gnt)));

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel W-bit registered mux with round-robin / fixed-priority arbitration.
//   clk, rst   : clock, synchronous active-high reset
//   rr_en      : 1 = round-robin, 0 = fixed priority (lowest index)
//   in_data    : packed channel data, channel k at [k*W +: W]
//   in_valid   : per-channel request
//   in_ready   : per-channel accept (one-hot or zero)
//   out_data   : registered winning data
//   out_sel    : registered winning channel index
//   out_valid  : output register holds a word
//   out_ready  : consumer takes out_data this cycle
module rr_mux_arb
  import ddco_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int W    = DEF_W,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rr_en,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]    ch_data [N];
  logic [N-1:0]    gnt;
  logic [SELW-1:0] gnt_idx;
  logic            any;
  logic            load, xfer;

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            valid_q, valid_d;

  for (genvar c = 0; c < N; c++) begin : g_ch
    assign ch_data[c] = in_data[c*W +: W];
  end

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .rr_en   (rr_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Output stage can take a word when empty or being drained this cycle.
  assign load     = !valid_q || out_ready;
  assign xfer     = load && any && !rst;
  assign in_ready = xfer ? gnt : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      // Idle load cycle empties the register but keeps last data/sel.
      valid_d = any;
      if (any) begin
        data_d = ch_data[gnt_idx];
        sel_d  = gnt_idx;
      end
    end
    // Pointer only advances on round-robin transfers.
    if (xfer && rr_en) begin
      ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
module tb_rr_mux_arb;

  logic        clk;
  logic        rst;
  logic        rr_en;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;

  rr_mux_arb #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rr_en     (rr_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rr_en = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", out_data); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", out_sel); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got %b exp 0000", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rst_release_ready got %b exp 0001", in_ready); end
  endtask

  // Continues from reset release: all requesting, consumer always ready.
  task automatic test_rr_fairness();
    logic [1:0] exp_sel [5];
    exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2; exp_sel[3] = 2'd3; exp_sel[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_sel !== exp_sel[i]) begin errors++; $display("FAIL rr_sel[%0d] got %0d exp %0d", i, out_sel, exp_sel[i]); end
      checks++; if (out_data !== (8'hA0 + {6'd0, exp_sel[i]})) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, out_data, 8'hA0 + {6'd0, exp_sel[i]}); end
    end
    // Pointer is now 1.
  endtask

  task automatic test_fixed();
    rr_en = 1'b0; in_valid = 4'b1010;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL fix_ready got %b exp 0010", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_sel !== 2'd1 || out_data !== 8'hA1) begin errors++; $display("FAIL fix_ch1[%0d] got sel %0d data %h exp 1 A1", i, out_sel, out_data); end
    end
    in_valid = 4'b1000;
    #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL fix_ready3 got %b exp 1000", in_ready); end
    tick();
    checks++; if (out_sel !== 2'd3 || out_data !== 8'hA3) begin errors++; $display("FAIL fix_ch3 got sel %0d data %h exp 3 A3", out_sel, out_data); end
  endtask

  task automatic test_backpressure();
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'h5C};
    in_valid = 4'b0001;
    tick();
    checks++; if (out_data !== 8'h5C || out_valid !== 1'b1) begin errors++; $display("FAIL bp_load got data %h valid %b exp 5C 1", out_data, out_valid); end
    out_ready = 1'b0; in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, in_ready); end
      tick();
      checks++; if (out_data !== 8'h5C || out_valid !== 1'b1 || out_sel !== 2'd0) begin errors++; $display("FAIL bp_hold[%0d] got data %h valid %b sel %0d exp 5C 1 0", i, out_data, out_valid, out_sel); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", in_ready); end
    tick();
    checks++; if (out_data !== 8'hA1 || out_sel !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble got data %h sel %0d valid %b exp A1 1 1", out_data, out_sel, out_valid); end
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  endtask

  // Pointer still 1 (fixed mode never moves it).
  task automatic test_ptr_skip_idle();
    rr_en = 1'b1; in_valid = 4'b0010;
    tick();  // ch1 granted, P -> 2
    checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL skip_pre got sel %0d exp 1", out_sel); end
    in_valid = 4'b0001;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL skip_ready got %b exp 0001", in_ready); end
    tick();  // ch0 granted via wrap, P -> 1
    checks++; if (out_sel !== 2'd0 || out_data !== 8'hA0) begin errors++; $display("FAIL skip_ch0 got sel %0d data %h exp 0 A0", out_sel, out_data); end
    in_valid = 4'b0000;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b exp 0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'hA0 || out_sel !== 2'd0) begin errors++; $display("FAIL idle_hold got data %h sel %0d exp A0 0", out_data, out_sel); end
    tick();
    in_valid = 4'b1111;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL idle_ptr got %b exp 0010", in_ready); end
    tick();  // ch1, P -> 2
    checks++; if (out_sel !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL idle_resume got sel %0d valid %b exp 1 1", out_sel, out_valid); end
  endtask

  task automatic test_reset_mid();
    tick();  // ch2, P -> 3
    checks++; if (out_sel !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got sel %0d valid %b exp 2 1", out_sel, out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin errors++; $display("FAIL mid_rst got valid %b data %h sel %0d exp 0 00 0", out_valid, out_data, out_sel); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_release_ready got %b exp 0001", in_ready); end
    tick();
    checks++; if (out_sel !== 2'd0 || out_data !== 8'hA0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_first got sel %0d data %h valid %b exp 0 A0 1", out_sel, out_data, out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rr_fairness();
    test_fixed();
    test_backpressure();
    test_ptr_skip_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
